// File: rtl/mimm_dpram_arb.sv
// Port arbiter and zero-fill sequencer for one PKE MIMM dual-port RAM.
// Two requesters share the write and read ports; read returns are steered by owner tag.
module mimm_dpram_arb #(
    parameter int AW   = 8,
    parameter int DW   = 64,
    parameter int DCNT = 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_start,
    output logic          init_busy,
    input  logic          a_wr_req,
    input  logic          b_wr_req,
    input  logic [AW-1:0] a_waddr,
    input  logic [AW-1:0] b_waddr,
    input  logic [DW-1:0] a_wdata,
    input  logic [DW-1:0] b_wdata,
    output logic          a_wr_gnt,
    output logic          b_wr_gnt,
    input  logic          a_rd_req,
    input  logic          b_rd_req,
    input  logic [AW-1:0] a_raddr,
    input  logic [AW-1:0] b_raddr,
    output logic          a_rd_gnt,
    output logic          b_rd_gnt,
    output logic          a_rvld,
    output logic          b_rvld,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          a_rerr,
    output logic          b_rerr,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_wr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_rd,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_parityerr,
    output logic [7:0]    err_cnt,
    input  logic          err_clr
);

    localparam int LAST_I = DCNT - 1;
    localparam logic [AW-1:0] LAST = LAST_I[AW-1:0];

    typedef enum logic {FILL, IDLE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic          idle;
    logic          w_last, r_last;
    logic          w_sel_b, r_sel_b;
    logic [AW-1:0] r_addr;
    logic          r_ok;
    logic          tag_vld, tag_sel;
    logic          err_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            FILL: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            IDLE: begin
                if (init_start) begin
                    state_nx = FILL;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = FILL;
                cnt_nx   = '0;
            end
        endcase
    end

    assign init_busy = (state == FILL) && !rst;
    assign idle      = (state == IDLE) && !rst;

    // w_last/r_last = 1 means B won the last conflict on that port
    assign w_sel_b  = b_wr_req && (!a_wr_req || !w_last);
    assign a_wr_gnt = idle && a_wr_req && !w_sel_b;
    assign b_wr_gnt = idle && w_sel_b;

    assign ram_wr    = init_busy || a_wr_gnt || b_wr_gnt;
    assign ram_waddr = init_busy ? cnt : (w_sel_b ? b_waddr : a_waddr);
    assign ram_wdata = init_busy ? '0 : (w_sel_b ? b_wdata : a_wdata);

    // a read hitting the word being written waits one cycle for the new data
    assign r_sel_b  = b_rd_req && (!a_rd_req || !r_last);
    assign r_addr   = r_sel_b ? b_raddr : a_raddr;
    assign r_ok     = idle && (a_rd_req || b_rd_req)
                      && !(ram_wr && (ram_waddr == r_addr));
    assign a_rd_gnt = r_ok && !r_sel_b;
    assign b_rd_gnt = r_ok && r_sel_b;

    assign ram_rd    = a_rd_gnt || b_rd_gnt;
    assign ram_raddr = r_addr;

    assign err_inc = ram_parityerr && tag_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_last  <= 1'b1;
            r_last  <= 1'b1;
            tag_vld <= 1'b0;
            tag_sel <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (idle && a_wr_req && b_wr_req)
                w_last <= w_sel_b;
            if (r_ok && a_rd_req && b_rd_req)
                r_last <= r_sel_b;
            tag_vld <= ram_rd;
            tag_sel <= r_sel_b;
            if (err_clr)
                err_cnt <= {7'd0, err_inc};
            else if (err_inc && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign a_rvld  = !rst && tag_vld && !tag_sel;
    assign b_rvld  = !rst && tag_vld && tag_sel;
    assign a_rerr  = a_rvld && ram_parityerr;
    assign b_rerr  = b_rvld && ram_parityerr;
    assign a_rdata = ram_rdata;
    assign b_rdata = ram_rdata;

endmodule

// File: tb/tb_mimm_dpram_arb.sv
// Bench for mimm_dpram_arb: a simple RAM environment plus a read-return scoreboard.
// Each scenario task drives stimulus, checks grants inline and queues expected returns.
module tb_mimm_dpram_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_start = 1'b0;
    logic        init_busy;
    logic        a_wr_req = 1'b0, b_wr_req = 1'b0;
    logic [7:0]  a_waddr = '0, b_waddr = '0;
    logic [63:0] a_wdata = '0, b_wdata = '0;
    logic        a_wr_gnt, b_wr_gnt;
    logic        a_rd_req = 1'b0, b_rd_req = 1'b0;
    logic [7:0]  a_raddr = '0, b_raddr = '0;
    logic        a_rd_gnt, b_rd_gnt;
    logic        a_rvld, b_rvld;
    logic [63:0] a_rdata, b_rdata;
    logic        a_rerr, b_rerr;
    logic [7:0]  ram_waddr, ram_raddr;
    logic        ram_wr, ram_rd;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata = '0;
    logic        pe = 1'b0;
    logic [7:0]  err_cnt;
    logic        err_clr = 1'b0;

    int vec = 0;
    int errs = 0;

    typedef struct packed {
        logic        b;
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t q[$];
    exp_t me;
    logic [63:0] mem [256];

    always #5 clk = ~clk;

    mimm_dpram_arb dut (
        .clk(clk), .rst(rst),
        .init_start(init_start), .init_busy(init_busy),
        .a_wr_req(a_wr_req), .b_wr_req(b_wr_req),
        .a_waddr(a_waddr), .b_waddr(b_waddr),
        .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_wr_gnt(a_wr_gnt), .b_wr_gnt(b_wr_gnt),
        .a_rd_req(a_rd_req), .b_rd_req(b_rd_req),
        .a_raddr(a_raddr), .b_raddr(b_raddr),
        .a_rd_gnt(a_rd_gnt), .b_rd_gnt(b_rd_gnt),
        .a_rvld(a_rvld), .b_rvld(b_rvld),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .a_rerr(a_rerr), .b_rerr(b_rerr),
        .ram_waddr(ram_waddr), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rd(ram_rd),
        .ram_rdata(ram_rdata), .ram_parityerr(pe),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always @(posedge clk) begin
        if (ram_wr) mem[ram_waddr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_raddr];
    end

    always @(posedge clk) begin
        #3;
        if (a_rvld && b_rvld) begin
            vec++;
            errs++;
            $display("FAIL rvld_both: a_rvld=%b b_rvld=%b, want one", a_rvld, b_rvld);
        end else if (a_rvld || b_rvld) begin
            vec++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL rvld_extra: a_rvld=%b b_rvld=%b, want none", a_rvld, b_rvld);
            end else begin
                me = q.pop_front();
                if (b_rvld !== me.b
                    || (b_rvld ? b_rdata : a_rdata) !== me.d
                    || (b_rvld ? b_rerr : a_rerr) !== me.e
                    || (b_rvld ? a_rerr : b_rerr) !== 1'b0) begin
                    errs++;
                    $display("FAIL rdata: got owner=%b data=%h rerr a/b=%b/%b, want owner=%b data=%h rerr=%b",
                             b_rvld, b_rvld ? b_rdata : a_rdata, a_rerr, b_rerr,
                             me.b, me.d, me.e);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic b, input logic [63:0] d, input logic e);
        exp_t t;
        t.b = b;
        t.d = d;
        t.e = e;
        q.push_back(t);
    endtask

    task automatic test_reset();
        a_wr_req = 1'b1;
        b_rd_req = 1'b1;
        repeat (3) nxt();
        #1;
        vec++;
        if (init_busy !== 1'b0 || ram_wr !== 1'b0 || ram_rd !== 1'b0
            || {a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt} !== 4'b0
            || {a_rvld, b_rvld, a_rerr, b_rerr} !== 4'b0 || err_cnt !== 8'd0) begin
            errs++;
            $display("FAIL reset: busy=%b wr=%b rd=%b gnt=%b%b%b%b cnt=%0d, want all 0",
                     init_busy, ram_wr, ram_rd, a_wr_gnt, b_wr_gnt,
                     a_rd_gnt, b_rd_gnt, err_cnt);
        end
        nxt();
        a_wr_req = 1'b0;
        b_rd_req = 1'b0;
    endtask

    task automatic test_fill();
        rst = 1'b0;
        a_rd_req = 1'b1;
        a_raddr = 8'h10;
        for (int i = 0; i < 256; i++) begin
            #1;
            vec++;
            if (ram_wr !== 1'b1 || ram_waddr !== 8'(i) || ram_wdata !== 64'd0
                || init_busy !== 1'b1 || a_rd_gnt !== 1'b0) begin
                errs++;
                $display("FAIL fill: wr=%b addr=%0d data=%h busy=%b gnt=%b, want 1 %0d 0 1 0",
                         ram_wr, ram_waddr, ram_wdata, init_busy, a_rd_gnt, i);
            end
            nxt();
        end
        #1;
        vec++;
        if (init_busy !== 1'b0 || a_rd_gnt !== 1'b1 || ram_raddr !== 8'h10) begin
            errs++;
            $display("FAIL fill_end: busy=%b a_rd_gnt=%b raddr=%h, want 0 1 10",
                     init_busy, a_rd_gnt, ram_raddr);
        end
        push(1'b0, 64'd0, 1'b0);
        nxt();
        a_rd_req = 1'b0;
    endtask

    task automatic test_write_rr();
        logic eb;
        for (int i = 0; i < 4; i++) begin
            a_wr_req = 1'b1;
            b_wr_req = 1'b1;
            a_waddr = 8'h01;
            b_waddr = 8'h02;
            a_wdata = 64'h100 + 64'(i);
            b_wdata = 64'h200 + 64'(i);
            eb = (i % 2) == 1;
            #1;
            vec++;
            if (a_wr_gnt !== !eb || b_wr_gnt !== eb
                || ram_waddr !== (eb ? 8'h02 : 8'h01)
                || ram_wdata !== (eb ? 64'h200 : 64'h100) + 64'(i)) begin
                errs++;
                $display("FAIL wr_rr%0d: gnt a/b=%b/%b addr=%h, want b=%b", i,
                         a_wr_gnt, b_wr_gnt, ram_waddr, eb);
            end
            nxt();
        end
        a_wr_req = 1'b0;
        b_wr_req = 1'b0;
        a_rd_req = 1'b1;
        a_raddr = 8'h01;
        #1;
        vec++;
        if (a_rd_gnt !== 1'b1) begin
            errs++;
            $display("FAIL rd_a01: gnt=%b, want 1", a_rd_gnt);
        end
        push(1'b0, 64'h102, 1'b0);
        nxt();
        a_rd_req = 1'b0;
        b_rd_req = 1'b1;
        b_raddr = 8'h02;
        #1;
        vec++;
        if (b_rd_gnt !== 1'b1) begin
            errs++;
            $display("FAIL rd_b02: gnt=%b, want 1", b_rd_gnt);
        end
        push(1'b1, 64'h203, 1'b0);
        nxt();
        b_rd_req = 1'b0;
    endtask

    task automatic test_collision();
        b_wr_req = 1'b1;
        b_waddr = 8'h33;
        b_wdata = 64'hDEAD;
        a_rd_req = 1'b1;
        a_raddr = 8'h33;
        #1;
        vec++;
        if (b_wr_gnt !== 1'b1 || a_rd_gnt !== 1'b0 || ram_rd !== 1'b0) begin
            errs++;
            $display("FAIL coll_stall: wr_gnt=%b rd_gnt=%b rd=%b, want 1 0 0",
                     b_wr_gnt, a_rd_gnt, ram_rd);
        end
        nxt();
        b_wr_req = 1'b0;
        #1;
        vec++;
        if (a_rd_gnt !== 1'b1) begin
            errs++;
            $display("FAIL coll_gnt: rd_gnt=%b, want 1", a_rd_gnt);
        end
        push(1'b0, 64'hDEAD, 1'b0);
        nxt();
        a_rd_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic eb;
        a_rd_req = 1'b1;
        b_rd_req = 1'b1;
        a_raddr = 8'h01;
        b_raddr = 8'h02;
        for (int i = 0; i < 4; i++) begin
            eb = (i % 2) == 1;
            #1;
            vec++;
            if (a_rd_gnt !== !eb || b_rd_gnt !== eb
                || ram_raddr !== (eb ? 8'h02 : 8'h01)) begin
                errs++;
                $display("FAIL rd_rr%0d: gnt a/b=%b/%b raddr=%h, want b=%b", i,
                         a_rd_gnt, b_rd_gnt, ram_raddr, eb);
            end
            push(eb, eb ? 64'h203 : 64'h102, 1'b0);
            nxt();
        end
        a_rd_req = 1'b0;
        b_rd_req = 1'b0;
        nxt();
        nxt();
    endtask

    task automatic test_parity();
        b_rd_req = 1'b1;
        b_raddr = 8'h02;
        #1;
        push(1'b1, 64'h203, 1'b1);
        nxt();
        b_rd_req = 1'b0;
        pe = 1'b1;
        nxt();
        pe = 1'b0;
        #1;
        vec++;
        if (err_cnt !== 8'd1) begin
            errs++;
            $display("FAIL err_one: err_cnt=%0d, want 1", err_cnt);
        end
        nxt();
        for (int i = 0; i < 300; i++) begin
            a_rd_req = 1'b1;
            a_raddr = 8'h01;
            pe = (i > 0);
            #1;
            push(1'b0, 64'h102, 1'b1);
            nxt();
        end
        a_rd_req = 1'b0;
        pe = 1'b1;
        nxt();
        pe = 1'b0;
        #1;
        vec++;
        if (err_cnt !== 8'd255) begin
            errs++;
            $display("FAIL err_sat: err_cnt=%0d, want 255", err_cnt);
        end
        nxt();
        a_rd_req = 1'b1;
        #1;
        push(1'b0, 64'h102, 1'b1);
        nxt();
        a_rd_req = 1'b0;
        pe = 1'b1;
        err_clr = 1'b1;
        nxt();
        pe = 1'b0;
        err_clr = 1'b0;
        #1;
        vec++;
        if (err_cnt !== 8'd1) begin
            errs++;
            $display("FAIL err_clr_inc: err_cnt=%0d, want 1", err_cnt);
        end
        nxt();
        pe = 1'b1;
        err_clr = 1'b1;
        nxt();
        err_clr = 1'b0;
        nxt();
        pe = 1'b0;
        #1;
        vec++;
        if (err_cnt !== 8'd0) begin
            errs++;
            $display("FAIL err_clr_only: err_cnt=%0d, want 0", err_cnt);
        end
        nxt();
    endtask

    task automatic test_init();
        init_start = 1'b1;
        #1;
        vec++;
        if (init_busy !== 1'b0 || ram_wr !== 1'b0) begin
            errs++;
            $display("FAIL init_idle: busy=%b wr=%b, want 0 0", init_busy, ram_wr);
        end
        nxt();
        init_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            vec++;
            if (ram_waddr !== 8'(i) || init_busy !== 1'b1) begin
                errs++;
                $display("FAIL init_fill: addr=%0d busy=%b, want %0d 1",
                         ram_waddr, init_busy, i);
            end
            nxt();
        end
        rst = 1'b1;
        #1;
        vec++;
        if (ram_wr !== 1'b0 || init_busy !== 1'b0) begin
            errs++;
            $display("FAIL init_rst: wr=%b busy=%b, want 0 0", ram_wr, init_busy);
        end
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            init_start = (i == 50);
            #1;
            vec++;
            if (ram_wr !== 1'b1 || ram_waddr !== 8'(i) || init_busy !== 1'b1) begin
                errs++;
                $display("FAIL refill: wr=%b addr=%0d busy=%b, want 1 %0d 1",
                         ram_wr, ram_waddr, init_busy, i);
            end
            nxt();
        end
        init_start = 1'b1;
        #1;
        vec++;
        if (init_busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_entry: busy=%b, want 0", init_busy);
        end
        nxt();
        init_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            #1;
            vec++;
            if (ram_waddr !== 8'(i) || init_busy !== 1'b1) begin
                errs++;
                $display("FAIL restart: addr=%0d busy=%b, want %0d 1",
                         ram_waddr, init_busy, i);
            end
            nxt();
        end
        #1;
        vec++;
        if (init_busy !== 1'b0) begin
            errs++;
            $display("FAIL restart_end: busy=%b, want 0", init_busy);
        end
        nxt();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_rr();
        test_collision();
        test_back_to_back();
        test_parity();
        test_init();
        nxt();
        vec++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d returns pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/mimm_dpram_arb.md
# mimm_dpram_arb

Arbiter and initialisation sequencer for one PKE MIMM dual-port RAM (one read port, one write port, 1-cycle read latency, per-byte parity error flag). It shares the write and read ports between two requesters (A: PKE datapath, B: bus/DMA side) with independent round-robin arbitration per port. It zero-fills the RAM after reset or on command so that parity is valid before first use. It routes read data and parity errors back to the requester that owns each read, and keeps a saturating parity-error count.

## Interface
- `AW`, 8: RAM address width.
- `DW`, 64: RAM data width.
- `DCNT`, 2**AW: number of valid words. Init fills addresses 0..DCNT-1.
- `clk` in 1: clock, the same clock that drives the RAM.
- `rst` in 1: reset, synchronous, active-high.
- `init_start` in 1: pulse that starts a zero-fill. Ignored while `init_busy`.
- `init_busy` out 1: zero-fill in progress.
- `a_wr_req`, `b_wr_req` in 1: write requests. Each is held until granted.
- `a_waddr`, `b_waddr` in AW: write addresses.
- `a_wdata`, `b_wdata` in DW: write data.
- `a_wr_gnt`, `b_wr_gnt` out 1: write grant. Combinational; the write occurs in the same cycle.
- `a_rd_req`, `b_rd_req` in 1: read requests. Each is held until granted.
- `a_raddr`, `b_raddr` in AW: read addresses.
- `a_rd_gnt`, `b_rd_gnt` out 1: read grant. Combinational.
- `a_rvld`, `b_rvld` out 1: read data valid, one cycle after the grant.
- `a_rdata`, `b_rdata` out DW: read data. Both are driven from `ram_rdata`, qualified by the matching `*_rvld`.
- `a_rerr`, `b_rerr` out 1: parity error on the returned word.
- `ram_waddr` out AW, `ram_wr` out 1, `ram_wdata` out DW: RAM write port.
- `ram_raddr` out AW, `ram_rd` out 1: RAM read port.
- `ram_rdata` in DW, `ram_parityerr` in 1: RAM read return.
- `err_cnt` out 8: saturating count of parity errors.
- `err_clr` in 1: clears `err_cnt`.

## Operation

**Init state machine**
- States: FILL, IDLE. `rst` forces FILL with the fill counter at 0.
- FILL:
  - drives `ram_wr`=1, `ram_waddr`=counter, `ram_wdata`=0;
  - counter increments each cycle;
  - after address DCNT-1 is written, the next state is IDLE.
- IDLE: `init_start`=1 moves to FILL with the counter at 0.
- `init_busy` = (state==FILL) && !rst.
- All requester grants are 0 while `init_busy`.

**Write arbitration (IDLE only)**
- One requester active: that requester is granted.
- Both active: the requester not granted last on this port wins.
- The last-winner register updates only when both requested.
- On reset the last-winner is B, so A wins the first conflict.
- Granted address and data are muxed onto `ram_w*`. `ram_wr` = any write grant.

**Read arbitration (IDLE only)**
- Round-robin with the same rules as the write port, using its own last-winner register.
- Collision stall: if the read candidate's address equals the address being written this cycle (`ram_wr` && equal), no read grant is issued that cycle. The read is granted the cycle after the write.
- `ram_rd` = any read grant. `ram_raddr` = granted address.

**Read return**
- A registered owner tag is captured with each read grant: {vld, sel}.
- In the next cycle:
  - `x_rvld` = tag.vld && owner matches;
  - `x_rerr` = `x_rvld` && `ram_parityerr`.

**Error counter**
- +1 on each cycle with `ram_parityerr` && tag.vld. Saturates at 255.
- `err_clr` together with an increment gives 1. `err_clr` alone gives 0.

## Timing
- Reset values:
  - `init_busy`, `ram_wr`, `ram_rd`, all grants and all `*_rvld`/`*_rerr` are 0 while `rst`=1;
  - `err_cnt`=0 and the owner tag is invalid.
- First cycle after `rst` falls: FILL writes address 0, `init_busy`=1.
- Fill length is exactly DCNT cycles. `init_busy` falls in the cycle after address DCNT-1 is written, and grants are possible in that cycle.
- `rst` asserted mid-fill restarts the fill from address 0.
- `init_start` arriving in the cycle IDLE is entered starts a new fill immediately.
- Grant to data latency: 1 cycle. Back-to-back reads are allowed, one per cycle.
- Requests asserted during FILL wait. They are not dropped.

## Test plan
- Reset with DCNT=256: `ram_wr` runs for 256 consecutive cycles with addresses 0..255 and data 0. `init_busy` falls, then a read of address 0x10 by A returns `a_rdata`=0, `a_rvld` one cycle after the grant, `a_rerr`=0.
- A and B both hold write requests for 4 cycles (A to 0x01, B to 0x02, each re-requesting): grants go A,B,A,B. Reads then show the last data written at each address.
- B writes 0x33 with 0xDEAD while A reads 0x33 in the same cycle: A's read is stalled one cycle, then granted, and returns 0xDEAD.
- Both read back-to-back for 4 cycles: owners alternate A,B,A,B. Each `*_rvld` is seen exactly once per grant and never on both requesters in the same cycle.
- Force `ram_parityerr`=1 on the return of B's read: `b_rerr`=1, `a_rerr`=0, `err_cnt`=1. After 300 forced errors `err_cnt`=255. `err_clr` together with an error gives 1.
- Assert `rst` at fill address 100, release it, then assert `init_start` during FILL: the fill restarts at 0, runs 256 cycles, and the mid-fill `init_start` has no effect.
